// File: rtl/seg_clock_gen.sv
// seg_clock_gen: segment-driven gated clock generator fed by a show-ahead FIFO.
// Optional mistrigger echo check is built when SEG_CLOCK_GEN_MISTRIG_EN is defined.
module seg_clock_gen #(
    parameter int CNT_W = 48,
    parameter int RPT_W = 32,
    parameter int NCH   = 4
) (
    input  logic                     refclk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     retrigger,
    input  logic [2*CNT_W+RPT_W-1:0] seg_data,
    input  logic                     seg_valid,
    output logic                     seg_ready,
    input  logic [NCH-1:0]           ch_enable,
    output logic [NCH-1:0]           clk_out,
    output logic                     flush,
    output logic [1:0]               state,
    output logic [15:0]              n_segs,
    output logic [31:0]              n_samples,
    input  logic                     toggle_in,
    output logic                     toggle_out,
    output logic [31:0]              mistrig_sample
);

    localparam int SEG_W = 2*CNT_W + RPT_W;
    localparam logic [CNT_W:0]   P_ONE = {{CNT_W{1'b0}}, 1'b1};
    localparam logic [RPT_W-1:0] R_ONE = {{(RPT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GEN  = 2'd1,
        S_WAIT = 2'd2
    } st_t;

    st_t              st;
    logic [CNT_W-1:0] on_r;
    logic [CNT_W:0]   per_last;
    logic [CNT_W:0]   p;
    logic [CNT_W:0]   p_nx;
    logic [RPT_W-1:0] rpt_last;
    logic [RPT_W-1:0] rep;
    logic             lvl;
    logic             lvl_nx;
    logic             rise_int;
    logic [2:0]       rt_q;
    logic             rt_rise;
    logic             last_cyc;
    logic             starting;

    logic [CNT_W-1:0] d_on;
    logic [CNT_W-1:0] d_off;
    logic [RPT_W-1:0] d_rpt;
    logic [CNT_W:0]   d_sum;
    logic             d_zero;

    assign d_on   = seg_data[SEG_W-1 -: CNT_W];
    assign d_off  = seg_data[CNT_W+RPT_W-1 -: CNT_W];
    assign d_rpt  = seg_data[RPT_W-1:0];
    assign d_sum  = {1'b0, d_on} + {1'b0, d_off};
    assign d_zero = (d_sum == '0) && (d_rpt == '0);

    assign state    = st;
    assign last_cyc = (st == S_GEN) && (p == per_last) && (rep == rpt_last);
    assign rt_rise  = rt_q[1] & ~rt_q[2];
    assign starting = (st == S_IDLE) && seg_ready;
    assign p_nx     = (p == per_last) ? '0 : p + P_ONE;
    assign rise_int = lvl_nx & ~lvl;

    // Pop strobe: the head segment is consumed at the edge where this is high
    always_comb begin
        seg_ready = 1'b0;
        if (!abort) begin
            unique case (st)
                S_IDLE:  seg_ready = start & seg_valid;
                S_GEN:   seg_ready = last_cyc & seg_valid;
                S_WAIT:  seg_ready = rt_rise & seg_valid;
                default: seg_ready = 1'b0;
            endcase
        end
    end

    // Internal level for the cycle after the coming edge
    always_comb begin
        lvl_nx = 1'b0;
        if (abort)
            lvl_nx = 1'b0;
        else if (seg_ready)
            lvl_nx = (d_on != '0);
        else if ((st == S_GEN) && !last_cyc)
            lvl_nx = (p_nx < {1'b0, on_r});
    end

    // Two-flop retrigger synchroniser plus edge-detect history
    always_ff @(posedge refclk or posedge reset) begin
        if (reset)
            rt_q <= '0;
        else
            rt_q <= {rt_q[1:0], retrigger};
    end

    // Sequencer: state, segment capture, phase/repeat counters, outputs
    always_ff @(posedge refclk or posedge reset) begin
        if (reset) begin
            st        <= S_IDLE;
            on_r      <= '0;
            per_last  <= '0;
            rpt_last  <= '0;
            p         <= '0;
            rep       <= '0;
            lvl       <= 1'b0;
            clk_out   <= '0;
            flush     <= 1'b0;
            n_segs    <= '0;
            n_samples <= '0;
        end else begin
            flush   <= 1'b0;
            lvl     <= lvl_nx;
            clk_out <= {NCH{lvl_nx}} & ch_enable;

            if (starting) begin
                n_segs    <= 16'd1;
                n_samples <= rise_int ? 32'd1 : 32'd0;
            end else begin
                if (seg_ready)
                    n_segs <= n_segs + 16'd1;
                if (rise_int)
                    n_samples <= n_samples + 32'd1;
            end

            if (abort) begin
                st    <= S_IDLE;
                flush <= 1'b1;
                p     <= '0;
                rep   <= '0;
            end else if (seg_ready) begin
                on_r     <= d_on;
                per_last <= (d_sum == '0) ? '0 : d_sum - P_ONE;
                rpt_last <= (d_rpt == '0) ? '0 : d_rpt - R_ONE;
                p        <= '0;
                rep      <= '0;
                st       <= d_zero ? S_WAIT : S_GEN;
            end else begin
                unique case (st)
                    S_GEN: begin
                        if (last_cyc) begin
                            st    <= S_IDLE;
                            flush <= 1'b1;
                            p     <= '0;
                            rep   <= '0;
                        end else begin
                            p <= p_nx;
                            if (p == per_last)
                                rep <= rep + R_ONE;
                        end
                    end
                    S_WAIT: begin
                        if (rt_rise) begin
                            st    <= S_IDLE;
                            flush <= 1'b1;
                        end
                    end
                    default: begin
                        p   <= '0;
                        rep <= '0;
                    end
                endcase
            end
        end
    end

`ifdef SEG_CLOCK_GEN_MISTRIG_EN
    logic [31:0] ns_base;

    assign ns_base = starting ? '0 : n_samples;

    // Toggle echo and capture of the first sample whose echo disagrees
    always_ff @(posedge refclk or posedge reset) begin
        if (reset) begin
            toggle_out     <= 1'b0;
            mistrig_sample <= '0;
        end else begin
            if (rise_int)
                toggle_out <= ~toggle_out;
            if (rise_int && (toggle_out != toggle_in) &&
                (starting || (mistrig_sample == '0)))
                mistrig_sample <= ns_base + 32'd1;
            else if (starting)
                mistrig_sample <= '0;
        end
    end
`else
    logic unused_toggle_in;

    assign unused_toggle_in = toggle_in;
    assign toggle_out       = 1'b0;
    assign mistrig_sample   = '0;
`endif

endmodule

// File: tb/tb_seg_clock_gen.sv
// tb_seg_clock_gen: directed and randomized checks of seg_clock_gen
// against a segment-expansion reference model.
module tb_seg_clock_gen;

    typedef struct {
        int unsigned on;
        int unsigned off;
        int unsigned rpt;
    } seg_t;

    logic         refclk = 1'b0;
    logic         reset;
    logic         start;
    logic         abort;
    logic         retrigger;
    logic [127:0] seg_data;
    logic         seg_valid;
    logic         seg_ready;
    logic [3:0]   ch_enable;
    logic [3:0]   clk_out;
    logic         flush;
    logic [1:0]   state;
    logic [15:0]  n_segs;
    logic [31:0]  n_samples;
    logic         toggle_in;
    logic         toggle_out;
    logic [31:0]  mistrig_sample;

    int checks = 0;
    int errors = 0;

    seg_t         plan[$];
    logic [127:0] fifo[$];

    seg_clock_gen dut (
        .refclk         (refclk),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .retrigger      (retrigger),
        .seg_data       (seg_data),
        .seg_valid      (seg_valid),
        .seg_ready      (seg_ready),
        .ch_enable      (ch_enable),
        .clk_out        (clk_out),
        .flush          (flush),
        .state          (state),
        .n_segs         (n_segs),
        .n_samples      (n_samples),
        .toggle_in      (toggle_in),
        .toggle_out     (toggle_out),
        .mistrig_sample (mistrig_sample)
    );

    always #5 refclk = ~refclk;

    function automatic logic [127:0] pack(input seg_t s);
        return {48'(s.on), 48'(s.off), 32'(s.rpt)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifo();
        seg_valid = (fifo.size() > 0);
        seg_data  = (fifo.size() > 0) ? fifo[0] : '0;
    endtask

    task automatic push(input int unsigned on, input int unsigned off,
                        input int unsigned rpt);
        seg_t s;
        s = '{on, off, rpt};
        fifo.push_back(pack(s));
        drive_fifo();
    endtask

    // one clock: note the pop strobe before the edge, then update the FIFO model
    task automatic tick();
        logic pop;
        #1;
        pop = seg_ready;
        @(posedge refclk);
        #1;
        if (pop === 1'b1 && fifo.size() > 0)
            void'(fifo.pop_front());
        if (flush === 1'b1)
            fifo.delete();
        drive_fifo();
    endtask

    task automatic do_reset();
        start     = 1'b0;
        abort     = 1'b0;
        retrigger = 1'b0;
        reset     = 1'b1;
        #2;
        reset     = 1'b0;
        fifo.delete();
        drive_fifo();
        @(posedge refclk);
        #1;
    endtask

    // expand the plan into the expected level stream and compare cycle by cycle
    task automatic run_plan(input logic [3:0] en, input string tag);
        bit          lv[$];
        bit          prev;
        bit          tgl;
        int unsigned nrise;
        int unsigned exp_mt;
        do_reset();
        foreach (plan[k]) begin
            int unsigned per;
            int unsigned reps;
            fifo.push_back(pack(plan[k]));
            per  = plan[k].on + plan[k].off;
            if (per == 0)
                per = 1;
            reps = (plan[k].rpt == 0) ? 1 : plan[k].rpt;
            for (int unsigned r = 0; r < reps; r++)
                for (int unsigned c = 0; c < per; c++)
                    lv.push_back(c < plan[k].on);
        end
        prev   = 1'b0;
        tgl    = 1'b0;
        nrise  = 0;
        exp_mt = 0;
        foreach (lv[i]) begin
            if (lv[i] && !prev) begin
                nrise++;
                if (tgl != 1'b0 && exp_mt == 0)
                    exp_mt = nrise;
                tgl = ~tgl;
            end
            prev = lv[i];
        end
        drive_fifo();
        ch_enable = en;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        foreach (lv[i]) begin
            check($sformatf("%s clk c%0d", tag, i), clk_out, {4{lv[i]}} & en);
            check($sformatf("%s st c%0d", tag, i), state, 2'd1);
            tick();
        end
        check({tag, " end state"}, state, 2'd0);
        check({tag, " end flush"}, flush, 1'b1);
        check({tag, " end clk"}, clk_out, 4'h0);
        check({tag, " n_segs"}, n_segs, plan.size());
        check({tag, " n_samples"}, n_samples, nrise);
`ifdef SEG_CLOCK_GEN_MISTRIG_EN
        check({tag, " toggle_out"}, toggle_out, tgl);
        check({tag, " mistrig"}, mistrig_sample, exp_mt);
`else
        check({tag, " toggle_out"}, toggle_out, 1'b0);
        check({tag, " mistrig"}, mistrig_sample, 32'd0);
`endif
        tick();
        check({tag, " flush once"}, flush, 1'b0);
    endtask

    initial begin
        bit b1100[4];
        b1100 = '{1'b1, 1'b1, 1'b0, 1'b0};
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        retrigger = 1'b0;
        toggle_in = 1'b0;
        ch_enable = 4'h0;
        drive_fifo();
        #12;
        check("rst state", state, 2'd0);
        check("rst clk", clk_out, 4'h0);
        check("rst ready", seg_ready, 1'b0);
        check("rst flush", flush, 1'b0);
        check("rst n_segs", n_segs, 16'd0);
        check("rst n_samples", n_samples, 32'd0);
        check("rst toggle", toggle_out, 1'b0);
        check("rst mistrig", mistrig_sample, 32'd0);
        reset = 1'b0;
        @(posedge refclk);
        #1;

        start = 1'b1;
        #1;
        check("start empty ready", seg_ready, 1'b0);
        tick();
        start = 1'b0;
        check("start empty state", state, 2'd0);
        check("start empty n_segs", n_segs, 16'd0);

        plan.delete();
        plan.push_back('{2, 3, 2});
        run_plan(4'hF, "p23x2");

        plan.delete();
        plan.push_back('{1, 1, 3});
        plan.push_back('{3, 1, 1});
        run_plan(4'hF, "b2b");

        plan.delete();
        plan.push_back('{1, 1, 4});
        run_plan(4'b0101, "en0101");

        plan.delete();
        plan.push_back('{0, 3, 1});
        plan.push_back('{2, 0, 2});
        plan.push_back('{0, 0, 2});
        plan.push_back('{1, 2, 0});
        run_plan(4'hF, "edges");

        for (int t = 0; t < 6; t++) begin
            int n;
            plan.delete();
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                seg_t s;
                do begin
                    s.on  = $urandom_range(0, 4);
                    s.off = $urandom_range(0, 4);
                    s.rpt = $urandom_range(0, 3);
                end while (s.on == 0 && s.off == 0 && s.rpt == 0);
                plan.push_back(s);
            end
            run_plan(4'($urandom_range(0, 15)), $sformatf("rnd%0d", t));
        end

        do_reset();
        ch_enable = 4'hF;
        push(2, 2, 1);
        push(0, 0, 0);
        push(1, 1, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wait pre clk%0d", i), clk_out, {4{b1100[i]}});
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            check($sformatf("wait st%0d", i), state, 2'd2);
            check($sformatf("wait clk%0d", i), clk_out, 4'h0);
            tick();
        end
        retrigger = 1'b1;
        tick();
        check("sync1 state", state, 2'd2);
        tick();
        check("sync2 state", state, 2'd2);
        check("sync2 clk", clk_out, 4'h0);
        tick();
        check("resume state", state, 2'd1);
        check("resume clk", clk_out, 4'hF);
        tick();
        check("resume low", clk_out, 4'h0);
        tick();
        check("wait end state", state, 2'd0);
        check("wait end flush", flush, 1'b1);
        check("wait n_segs", n_segs, 16'd3);
        check("wait n_samples", n_samples, 32'd2);

        do_reset();
        push(1, 1, 1);
        push(0, 0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("wait2 state", state, 2'd2);
        tick();
        tick();
        retrigger = 1'b1;
        tick();
        tick();
        check("wait2 hold", state, 2'd2);
        tick();
        check("wait2 idle", state, 2'd0);
        check("wait2 flush", flush, 1'b1);
        check("wait2 n_segs", n_segs, 16'd2);

        do_reset();
        push(10, 10, 5);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("abort pre clk%0d", i), clk_out, 4'hF);
            tick();
        end
        abort = 1'b1;
        start = 1'b1;
        push(1, 1, 1);
        #1;
        check("abort ready", seg_ready, 1'b0);
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("abort state", state, 2'd0);
        check("abort clk", clk_out, 4'h0);
        check("abort flush", flush, 1'b1);
        check("abort n_segs", n_segs, 16'd1);
        tick();
        check("abort flush once", flush, 1'b0);

        do_reset();
        push(1, 1, 1);
        push(1, 1, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        abort = 1'b1;
        #1;
        check("abort pop ready", seg_ready, 1'b0);
        tick();
        abort = 1'b0;
        check("abort pop state", state, 2'd0);
        check("abort pop n_segs", n_segs, 16'd1);
        check("abort pop flush", flush, 1'b1);

        do_reset();
        push(1, 1, 1);
        start = 1'b1;
        abort = 1'b1;
        #1;
        check("abort idle ready", seg_ready, 1'b0);
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("abort idle state", state, 2'd0);
        check("abort idle n_segs", n_segs, 16'd0);

        do_reset();
        push(10, 10, 5);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #3;
        reset = 1'b1;
        #1;
        check("mid rst state", state, 2'd0);
        check("mid rst clk", clk_out, 4'h0);
        check("mid rst n_segs", n_segs, 16'd0);
        check("mid rst n_samples", n_samples, 32'd0);
        check("mid rst flush", flush, 1'b0);
        #1;
        reset = 1'b0;
        fifo.delete();
        drive_fifo();
        @(posedge refclk);
        #1;
        check("post rst flush", flush, 1'b0);
        check("post rst state", state, 2'd0);
        check("post rst clk", clk_out, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_clock_gen.md
SEG_CLOCK_GEN -- requirements
Module: seg_clock_gen

Interface
REQ-001 Parameter CNT_W, default 48, width of on/off count fields.
REQ-002 Parameter RPT_W, default 32, width of repeat count field.
REQ-003 Parameter NCH, default 4, number of gated clock output channels.
REQ-004 Ports, in this order:
- refclk  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle generate trigger.
- abort  in  1  one-cycle abort trigger.
- retrigger  in  1  asynchronous retrigger level.
- seg_data  in  2*CNT_W+RPT_W  {on_counts, off_counts, repeat_counts}, MSB first; show-ahead FIFO head.
- seg_valid  in  1  seg_data holds a segment (FIFO not empty).
- seg_ready  out  1  combinational pop strobe; segment consumed at this edge.
- ch_enable  in  NCH  per-channel output enable.
- clk_out  out  NCH  registered generated clock per channel.
- flush  out  1  one-cycle FIFO flush request.
- state  out  2  0 IDLE, 1 GEN, 2 WAIT.
- n_segs  out  16  segments consumed since start.
- n_samples  out  32  rising edges generated since start.
- toggle_in  in  1  mistrigger echo input.
- toggle_out  out  1  mistrigger toggle output.
- mistrig_sample  out  32  first mistriggered sample index, 0 = none.

Function
REQ-005 States IDLE, GEN, WAIT; no other encodings reachable.
REQ-006 IDLE: clk_out=0, phase/repeat counters=0; start=1 with seg_valid=1 -> seg_ready=1, segment captured, n_segs/n_samples/mistrig_sample cleared, n_segs=1, next state GEN (or WAIT if segment all-zero).
REQ-007 IDLE with start=1 and seg_valid=0: start ignored, stays IDLE; start outside IDLE ignored.
REQ-008 GEN: phase counter p runs 0..on+off-1; internal level high when p<on, else low; clk_out[i] = level AND ch_enable[i], registered; first high cycle is the cycle after capture.
REQ-009 Period compare done in CNT_W+1 bits; on+off never overflows.
REQ-010 on=0: output low for whole period; off=0: output high for whole period; on=off=0 with repeat nonzero treated as period of 1 cycle low.
REQ-011 repeat_counts=0 treated as 1; segment lasts max(repeat,1) periods.
REQ-012 Last cycle of last period: seg_valid=1 -> seg_ready=1, next segment loaded at same edge, p=0, zero gap cycles; n_segs increments.
REQ-013 Last cycle of last period with seg_valid=0 -> IDLE, flush=1 one cycle, clk_out=0.
REQ-014 All-zero segment loaded -> WAIT, clk_out=0; retrigger passed through 2-FF synchroniser, rising edge detected.
REQ-015 WAIT: synchronised rising edge and seg_valid=1 -> pop, n_segs+1, load, GEN; edge with seg_valid=0 -> IDLE with flush pulse.
REQ-016 n_samples increments once per 0->1 transition of internal level (regardless of ch_enable); wraps at 2^32.
REQ-017 n_segs wraps at 2^16.
REQ-018 abort=1 in any state: next state IDLE, clk_out=0, flush=1 one cycle; abort wins over start, pop and retrigger in same cycle; seg_ready=0 that cycle.
REQ-019 Back-to-back segments of on=1,off=1 produce continuous refclk/2 output.

Reset
REQ-020 reset=1 asynchronously forces IDLE, clk_out=0, seg_ready=0, flush=0, n_segs=0, n_samples=0, toggle_out=0, mistrig_sample=0, synchroniser flops=0.
REQ-021 reset mid-segment discards captured segment; no flush issued by reset.

Configuration
REQ-022 Macro SEG_CLOCK_GEN_MISTRIG_EN defined: toggle_out inverts at each internal rising edge; at that edge if toggle_out!=toggle_in and mistrig_sample==0, mistrig_sample <= n_samples+1.
REQ-023 Macro undefined: toggle_out=0, mistrig_sample=0 constantly, toggle_in unused; all other behaviour identical.

Verification
REQ-024 Segment {on=2,off=3,rpt=2}, seg_valid then low, start -> pattern 11000 11000, flush pulse, IDLE, n_samples=2, n_segs=1.
REQ-025 Two segments {1,1,3},{3,1,1} queued -> 101010 1110 with no gap cycle, n_segs=2, n_samples=4.
REQ-026 Segments {2,2,1},{0,0,0},{1,1,1}; retrigger edge 10 cycles after WAIT entry -> clk_out low during WAIT, resumes 3 cycles after edge (sync+load), n_segs=3.
REQ-027 abort asserted at cycle 5 of {10,10,5} together with start -> IDLE next cycle, clk_out=0, flush=1, seg_ready=0.
REQ-028 ch_enable=4'b0101 on {1,1,4} -> clk_out[0],[2] toggle, clk_out[1],[3] stay 0, n_samples=4.
REQ-029 MISTRIG_EN defined, toggle_in tied 0, {1,1,4} -> mistrig_sample=2 after sample 2; undefined -> mistrig_sample=0.
